mips32: RTL and testbench
=========================

// Module: mips32
// PURPOSE
// - 5-stage in-order pipelined 32-bit MIPS-subset CPU core: IF, ID, EX, MEM, WB.
// - Unified word-addressed instruction/data memory and register file are internal.
// - No hazard detection and no forwarding; software inserts NOPs between dependent instructions.
// - Top-level block, standalone; memories are preloaded hierarchically by the bench.
// PARAMETERS
// - MEM_WORDS  1024  depth of unified memory Mem[0:MEM_WORDS-1]; address = low 10 bits
// - NREGS      32    register file depth Reg[0:31], 32-bit
// PORTS
// - clk1    in   1  single clock, all state updates on posedge
// - rst     in   1  synchronous, active-high reset
// - halted  out  1  core has retired HLT; reset value 0
// - Internal names Reg, Mem, Pc, halted, taken_branch are fixed (bench pokes them hierarchically).
// BEHAVIOUR
// - Encoding: op=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11], imm=IR[15:0].
// - imm is sign-extended to 32 bits.
// - RR ops write rd: ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
// - RM ops write rt: ADDI 001010, SUBI 001011, SLTI 001100.
// - Memory: LW 001000 (rt<=Mem[rs+imm]); SW 001001 (Mem[rs+imm]<=rt).
// - Branch: BEQZ 001110, BNEQZ 001101; target = NPC+imm.
// - HLT 111111.
// - Any other opcode decodes as HALT.
// - SLT/SLTI compare signed, result 1/0. MUL keeps low 32 bits. Arithmetic wraps mod 2^32.
// - Reset: Pc, halted and taken_branch <= 0. All pipeline IR/type registers <= NOP (no side effects).
// - Reg and Mem are NOT reset; their preload is preserved.
// - Reset mid-run discards all in-flight instructions.
// - IF: branch redirect applies if EX/MEM holds a branch whose condition matches.
//   Condition: cond = (A==0); BEQZ taken when cond=1, BNEQZ taken when cond=0.
//   On redirect: IR<=Mem[ALUOut], NPC=Pc<=ALUOut+1, taken_branch<=1.
//   Otherwise: IR<=Mem[Pc], NPC=Pc<=Pc+1.
// - ID: A=(rs==0)?0:Reg[rs], B=(rt==0)?0:Reg[rt]; classify type (RR, RM, LOAD, STORE, BRANCH, HALT).
// - EX: clears taken_branch. ALUOut computed per type:
//   RR: A op B. RM: A op imm. LOAD/STORE: A+imm, B passed on. BRANCH: NPC+imm, cond=(A==0).
// - MEM: LOAD reads Mem[ALUOut].
//   STORE writes Mem[ALUOut]<=B only if taken_branch==0 (suppresses stores squashed by a branch).
// - WB: effective only if taken_branch==0. RR writes rd; RM and LOAD write rt.
//   Writes to R0 are ignored. HALT sets halted<=1.
// - Once halted=1, all stages freeze (no fetch, no Reg/Mem writes) until rst.
// - Instructions younger than HLT never write back.
// - Latency: 5 cycles fetch to writeback.
//   Dependent reader needs >=2 instructions between it and producer (3rd ID sees WB-cycle+1).
// - Delay slots: instructions fetched after a taken branch up to redirect are squashed by taken_branch.
// STRUCTURE
// - Package mips32_pkg: opcode localparams, type enum {RR,RM,LOAD,STORE,BRANCH,HALT,NOP}.
// - Package mips32_pkg also holds field-slice helpers.
// - Optional sub-module mips32_alu (combinational op/A/B -> result); everything else in mips32.
// TESTING
// - Reg[k]=k; program: ADDI R1,R0,10; ADDI R2,R0,20; ADDI R3,R0,25; OR R7,R7,R7 x2; ADD R4,R1,R2; HLT.
//   -> R1=10, R2=20, R3=25, R4=30, halted=1.
// - ADDI R1,R0,7; 2 NOPs; SW R1,120(R0); 2 NOPs; LW R5,120(R0); HLT -> Mem[120]=7, R5=7.
// - SUB/SLT/MUL: R1=-3, R2=5 -> SLT R3,R1,R2 =1; SUB R4,R2,R1 =8; MUL R6,R1,R2 =-15 (32'hFFFFFFF1).
// - BEQZ R0 +2 with ADDI R8,R0,99 in shadow -> R8 unchanged; target instruction executes.
// - BNEQZ on zero reg not taken -> sequential execution continues.
// - Undefined opcode 0xcceeabc0 -> halts like HLT; later instructions have no effect.
// - rst held 1 cycle mid-program -> Pc=0, halted=0, Reg/Mem retain values, program restarts.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared opcodes, instruction/ALU type enums and instruction field helpers
// for the mips32 pipelined core.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  // ADD R0,R0,R0: decodes as RR but its R0 write is discarded
  localparam logic [31:0] NOP_IR = '0;

  typedef enum logic [2:0] {
    T_RR, T_RM, T_LOAD, T_STORE, T_BRANCH, T_HALT, T_NOP
  } itype_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } alu_op_e;

  function automatic logic [5:0] f_op(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [31:0] f_imm(input logic [31:0] ir);
    return {{16{ir[15]}}, ir[15:0]};
  endfunction

  function automatic itype_e decode_type(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return T_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return T_RM;
      OP_LW:                                         return T_LOAD;
      OP_SW:                                         return T_STORE;
      OP_BEQZ, OP_BNEQZ:                             return T_BRANCH;
      default:                                       return T_HALT;
    endcase
  endfunction

  function automatic alu_op_e alu_sel(input logic [5:0] op);
    case (op)
      OP_SUB, OP_SUBI: return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_SLT, OP_SLTI: return ALU_SLT;
      OP_MUL:          return ALU_MUL;
      default:         return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips32_alu.sv
// Combinational 32-bit ALU; arithmetic wraps, SLT is signed, MUL keeps the low word.
module mips32_alu
  import mips32_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      ALU_AND: y_o = a_i & b_i;
      ALU_OR:  y_o = a_i | b_i;
      ALU_SLT: y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_MUL: y_o = a_i * b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/mips32.sv
// 5-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with unified word
// memory and register file; no interlocks, software schedules around hazards.
module mips32 #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned NREGS     = 32
) (
  input  logic clk1,
  input  logic rst,
  output logic halted
);
  import mips32_pkg::*;

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] Reg [0:NREGS-1];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] Pc;
  logic        taken_branch;

  logic [31:0] if_id_ir_q, if_id_npc_q;

  itype_e      id_ex_type_q;
  logic [5:0]  id_ex_op_q;
  logic [4:0]  id_ex_dst_q;
  logic [31:0] id_ex_npc_q, id_ex_a_q, id_ex_b_q, id_ex_imm_q;

  itype_e      ex_mem_type_q;
  logic [5:0]  ex_mem_op_q;
  logic [4:0]  ex_mem_dst_q;
  logic [31:0] ex_mem_alu_q, ex_mem_b_q;
  logic        ex_mem_cond_q;

  itype_e      mem_wb_type_q;
  logic [4:0]  mem_wb_dst_q;
  logic [31:0] mem_wb_alu_q, mem_wb_lmd_q;

  logic        hlt_wb, adv, redirect, wb_we;
  logic [31:0] wb_data;
  itype_e      id_type_d;
  logic [4:0]  id_dst_d;
  logic [31:0] id_a_d, id_b_d;
  alu_op_e     alu_op;
  logic [31:0] alu_a, alu_b, alu_y;

  always_comb begin
    hlt_wb   = (mem_wb_type_q == T_HALT) && !taken_branch;
    adv      = !halted && !hlt_wb;
    redirect = (ex_mem_type_q == T_BRANCH) &&
               (((ex_mem_op_q == OP_BEQZ)  &&  ex_mem_cond_q) ||
                ((ex_mem_op_q == OP_BNEQZ) && !ex_mem_cond_q));
    wb_we    = !halted && !taken_branch && (mem_wb_dst_q != '0) &&
               ((mem_wb_type_q == T_RR) || (mem_wb_type_q == T_RM) ||
                (mem_wb_type_q == T_LOAD));
    wb_data  = (mem_wb_type_q == T_LOAD) ? mem_wb_lmd_q : mem_wb_alu_q;
  end

  // Register reads are write-first so a reader two slots behind its producer
  // sees the value retiring in the same cycle.
  always_comb begin
    id_type_d = decode_type(f_op(if_id_ir_q));
    id_dst_d  = (id_type_d == T_RR) ? f_rd(if_id_ir_q) : f_rt(if_id_ir_q);
    id_a_d    = '0;
    id_b_d    = '0;
    if (f_rs(if_id_ir_q) != '0)
      id_a_d = (wb_we && (mem_wb_dst_q == f_rs(if_id_ir_q))) ? wb_data : Reg[f_rs(if_id_ir_q)];
    if (f_rt(if_id_ir_q) != '0)
      id_b_d = (wb_we && (mem_wb_dst_q == f_rt(if_id_ir_q))) ? wb_data : Reg[f_rt(if_id_ir_q)];
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = id_ex_a_q;
    alu_b  = id_ex_imm_q;
    case (id_ex_type_q)
      T_RR: begin
        alu_op = alu_sel(id_ex_op_q);
        alu_b  = id_ex_b_q;
      end
      T_RM:     alu_op = alu_sel(id_ex_op_q);
      T_BRANCH: alu_a  = id_ex_npc_q;
      default:  ;
    endcase
  end

  mips32_alu u_alu (
    .op_i (alu_op),
    .a_i  (alu_a),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // A single taken_branch flag only covers one shadow slot when all stages
  // share one edge, so both shadow instructions are also turned into NOPs.
  always_ff @(posedge clk1) begin
    if (rst) begin
      Pc            <= '0;
      halted        <= 1'b0;
      taken_branch  <= 1'b0;
      if_id_ir_q    <= NOP_IR;
      id_ex_type_q  <= T_NOP;
      ex_mem_type_q <= T_NOP;
      mem_wb_type_q <= T_NOP;
    end else if (!halted) begin
      if (hlt_wb) begin
        halted <= 1'b1;
      end else begin
        taken_branch <= 1'b0;
        if (redirect) begin
          if_id_ir_q   <= Mem[ex_mem_alu_q[AW-1:0]];
          if_id_npc_q  <= ex_mem_alu_q + 32'd1;
          Pc           <= ex_mem_alu_q + 32'd1;
          taken_branch <= 1'b1;
        end else begin
          if_id_ir_q  <= Mem[Pc[AW-1:0]];
          if_id_npc_q <= Pc + 32'd1;
          Pc          <= Pc + 32'd1;
        end

        id_ex_type_q <= redirect ? T_NOP : id_type_d;
        id_ex_op_q   <= f_op(if_id_ir_q);
        id_ex_dst_q  <= id_dst_d;
        id_ex_npc_q  <= if_id_npc_q;
        id_ex_a_q    <= id_a_d;
        id_ex_b_q    <= id_b_d;
        id_ex_imm_q  <= f_imm(if_id_ir_q);

        ex_mem_type_q <= redirect ? T_NOP : id_ex_type_q;
        ex_mem_op_q   <= id_ex_op_q;
        ex_mem_dst_q  <= id_ex_dst_q;
        ex_mem_alu_q  <= alu_y;
        ex_mem_b_q    <= id_ex_b_q;
        ex_mem_cond_q <= (id_ex_a_q == '0);

        mem_wb_type_q <= ex_mem_type_q;
        mem_wb_dst_q  <= ex_mem_dst_q;
        mem_wb_alu_q  <= ex_mem_alu_q;
        if (ex_mem_type_q == T_LOAD)
          mem_wb_lmd_q <= Mem[ex_mem_alu_q[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst && adv && (ex_mem_type_q == T_STORE) && !taken_branch)
      Mem[ex_mem_alu_q[AW-1:0]] <= ex_mem_b_q;
  end

  always_ff @(posedge clk1) begin
    if (!rst && wb_we)
      Reg[mem_wb_dst_q] <= wb_data;
  end

endmodule

// File: tb/tb_mips32.sv
// Self-checking bench for mips32: preloads programs, runs them to HALT and
// compares architectural state against a scoreboard of expected results.
module tb_mips32;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b000010,
                         OR_ = 6'b000011, SLT = 6'b000100, MUL = 6'b000101,
                         LW  = 6'b001000, SW  = 6'b001001, ADDI = 6'b001010,
                         SUBI = 6'b001011, SLTI = 6'b001100, BNEQZ = 6'b001101,
                         BEQZ = 6'b001110;
  localparam logic [31:0] HLT = 32'hFC00_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic halted;

  mips32 #(.MEM_WORDS(1024), .NREGS(32)) dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    string       tag;
    int          kind;   // 0 register, 1 memory word, 2 redirect count
    int unsigned idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog[$];
  string       cur;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned taken_cnt = 0;
  int unsigned taken_base;

  always @(posedge clk1) if (dut.taken_branch === 1'b1) taken_cnt <= taken_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic exp_reg(input int unsigned r, input logic [31:0] v);
    sb.push_back('{$sformatf("%s:R%0d", cur, r), 0, r, v});
  endtask

  task automatic exp_mem(input int unsigned a, input logic [31:0] v);
    sb.push_back('{$sformatf("%s:Mem[%0d]", cur, a), 1, a, v});
  endtask

  task automatic exp_taken(input logic [31:0] n);
    sb.push_back('{$sformatf("%s:redirects", cur), 2, 0, n});
  endtask

  // Holds reset, preloads memory (HLT fill + program) and Reg[k]=k.
  task automatic start_prog(input string name);
    cur = name;
    rst = 1'b1;
    @(negedge clk1);
    for (int i = 0; i < 1024; i++) dut.Mem[i] = HLT;
    for (int k = 0; k < 32; k++) dut.Reg[k] = 32'(k);
    foreach (prog[i]) dut.Mem[i] = prog[i];
    @(negedge clk1);
  endtask

  task automatic release_rst();
    taken_base = taken_cnt;
    rst = 1'b0;
  endtask

  task automatic run_to_halt();
    int unsigned cyc;
    exp_t        e;
    logic [31:0] got;
    cyc = 0;
    while (halted !== 1'b1 && cyc < 300) begin
      @(negedge clk1);
      cyc++;
    end
    check_eq({cur, ":halted"}, 32'(halted), 32'd1);
    repeat (4) @(negedge clk1);
    check_eq({cur, ":halt_held"}, 32'(halted), 32'd1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       got = dut.Reg[e.idx];
        1:       got = dut.Mem[e.idx];
        default: got = taken_cnt - taken_base;
      endcase
      check_eq(e.tag, got, e.val);
    end
  endtask

  initial begin
    // Dependent ADD three slots after its producers
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 16'd10));
    prog.push_back(ri(ADDI, 2, 0, 16'd20));
    prog.push_back(ri(ADDI, 3, 0, 16'd25));
    prog.push_back(rr(OR_, 7, 7, 7));
    prog.push_back(rr(OR_, 7, 7, 7));
    prog.push_back(rr(ADD, 4, 1, 2));
    prog.push_back(HLT);
    start_prog("arith");
    check_eq("reset:Pc", dut.Pc, 32'd0);
    check_eq("reset:halted", 32'(halted), 32'd0);
    check_eq("reset:taken_branch", 32'(dut.taken_branch), 32'd0);
    exp_reg(1, 32'd10); exp_reg(2, 32'd20); exp_reg(3, 32'd25);
    exp_reg(4, 32'd30); exp_reg(7, 32'd7);  exp_reg(5, 32'd5);
    exp_taken(32'd0);
    release_rst();
    run_to_halt();

    // Store then load through memory, two NOPs between producer and reader
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 16'd7));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(ri(SW, 1, 0, 16'd120));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(ri(LW, 5, 0, 16'd120));
    prog.push_back(HLT);
    start_prog("ldst");
    exp_mem(120, 32'd7); exp_reg(5, 32'd7); exp_reg(1, 32'd7);
    release_rst();
    run_to_halt();

    // Signed compare, subtract, multiply and the remaining ALU ops
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 16'hFFFD));
    prog.push_back(ri(ADDI, 2, 0, 16'd5));
    prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(rr(SLT, 3, 1, 2));
    prog.push_back(rr(SUB, 4, 2, 1));
    prog.push_back(rr(MUL, 6, 1, 2));
    prog.push_back(rr(AND_, 9, 1, 2));
    prog.push_back(rr(OR_, 12, 1, 2));
    prog.push_back(rr(SLT, 14, 2, 1));
    prog.push_back(ri(SLTI, 10, 2, 16'hFFFF));
    prog.push_back(ri(SLTI, 13, 1, 16'hFFFE));
    prog.push_back(ri(SUBI, 11, 2, 16'd7));
    prog.push_back(HLT);
    start_prog("alu");
    exp_reg(1, 32'hFFFF_FFFD); exp_reg(3, 32'd1);  exp_reg(4, 32'd8);
    exp_reg(6, 32'hFFFF_FFF1); exp_reg(9, 32'd5);  exp_reg(12, 32'hFFFF_FFFD);
    exp_reg(14, 32'd0);        exp_reg(10, 32'd0); exp_reg(13, 32'd1);
    exp_reg(11, 32'hFFFF_FFFE);
    release_rst();
    run_to_halt();

    // Taken BEQZ: both shadow slots (ALU write and store) are squashed
    prog.delete();
    prog.push_back(ri(BEQZ, 0, 0, 16'd2));
    prog.push_back(ri(ADDI, 8, 0, 16'd99));
    prog.push_back(ri(SW, 1, 0, 16'd200));
    prog.push_back(ri(ADDI, 10, 0, 16'd55));
    prog.push_back(HLT);
    start_prog("beqz");
    exp_reg(8, 32'd8); exp_mem(200, HLT); exp_reg(10, 32'd55); exp_taken(32'd1);
    release_rst();
    run_to_halt();

    // BNEQZ on R0 falls through; BNEQZ on R5 is taken
    prog.delete();
    prog.push_back(ri(BNEQZ, 0, 0, 16'd2));
    prog.push_back(ri(ADDI, 8, 0, 16'd99));
    prog.push_back(ri(ADDI, 9, 0, 16'd77));
    prog.push_back(ri(ADDI, 10, 0, 16'd55));
    prog.push_back(ri(BNEQZ, 0, 5, 16'd2));
    prog.push_back(ri(ADDI, 11, 0, 16'd99));
    prog.push_back(ri(ADDI, 12, 0, 16'd99));
    prog.push_back(ri(ADDI, 13, 0, 16'd33));
    prog.push_back(HLT);
    start_prog("bneqz");
    exp_reg(8, 32'd99);  exp_reg(9, 32'd77);  exp_reg(10, 32'd55);
    exp_reg(11, 32'd11); exp_reg(12, 32'd12); exp_reg(13, 32'd33);
    exp_taken(32'd1);
    release_rst();
    run_to_halt();

    // Undefined opcode halts; younger instructions leave no trace
    prog.delete();
    prog.push_back(ri(ADDI, 1, 0, 16'd10));
    prog.push_back(32'hCCEE_ABC0);
    prog.push_back(ri(ADDI, 2, 0, 16'd20));
    prog.push_back(ri(SW, 3, 0, 16'd300));
    prog.push_back(ri(ADDI, 4, 0, 16'd44));
    start_prog("undef");
    exp_reg(1, 32'd10); exp_reg(2, 32'd2); exp_reg(4, 32'd4); exp_mem(300, HLT);
    release_rst();
    run_to_halt();

    // One-cycle reset mid-run: state kept, program restarts from 0
    prog.delete();
    prog.push_back(ri(ADDI, 20, 20, 16'd1));
    prog.push_back(NOP); prog.push_back(NOP); prog.push_back(NOP);
    prog.push_back(ri(SW, 20, 0, 16'd400));
    for (int i = 0; i < 25; i++) prog.push_back(NOP);
    start_prog("midrst");
    release_rst();
    repeat (12) @(negedge clk1);
    check_eq("midrst:Mem[400]_first_pass", dut.Mem[400], 32'd21);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    check_eq("midrst:Pc", dut.Pc, 32'd0);
    check_eq("midrst:halted", 32'(halted), 32'd0);
    check_eq("midrst:taken_branch", 32'(dut.taken_branch), 32'd0);
    check_eq("midrst:R20_kept", dut.Reg[20], 32'd21);
    exp_reg(20, 32'd22); exp_mem(400, 32'd22);
    run_to_halt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
